ram_portb_arbiter: RTL and testbench

//  Shares the data-side port B of the dual-port RAM between two requesters: the elbeth core

---
 rtl/elbeth_mem_pkg.sv | 17 +
 rtl/ram_portb_arbiter.sv | 118 +++++++++++
 tb/tb_ram_portb_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/elbeth_mem_pkg.sv
// Shared types and constants for the elbeth data-memory port B arbiter.
package elbeth_mem_pkg;

   localparam int unsigned DEF_AW = 32;
   localparam int unsigned DEF_DW = 32;
   localparam int unsigned DEF_BW = DEF_DW / 8;

   localparam logic REQ_CORE = 1'b0;
   localparam logic REQ_DMA  = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      OWN0,
      OWN1
   } state_e;

endpackage

// File: rtl/ram_portb_arbiter.sv
// Two-requester arbiter for RAM port B with registered command and routed read data.
// Optional round-robin conflict resolution with `define ARB_ROUND_ROBIN_EN.
module ram_portb_arbiter
   import elbeth_mem_pkg::*;
#(
   parameter int unsigned AW = DEF_AW,
   parameter int unsigned DW = DEF_DW,
   parameter int unsigned BW = DEF_BW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic [BW-1:0] we0,
   input  logic [BW-1:0] we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   input  logic          lock0,
   input  logic          lock1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          enb,
   output logic [BW-1:0] web,
   output logic [AW-1:0] addrb,
   output logic [DW-1:0] dinb,
   input  logic [DW-1:0] doutb
);

   state_e     state;
   logic       lock_q;
   logic       tag_q;
   logic       prio;
   logic       own0;
   logic       own1;
   logic [1:0] win;

   // Locked owner first, then conflict resolution by prio (requester index that wins ties).
   function automatic logic [1:0] pick(input logic r0, input logic r1, input logic o0,
                                       input logic o1, input logic pr);
      if (o0) return 2'b01;
      if (o1) return 2'b10;
      if (r0 && r1) return pr ? 2'b10 : 2'b01;
      return {r1, r0};
   endfunction

`ifdef ARB_ROUND_ROBIN_EN
   logic ptr_q;
   logic contested;
   assign prio      = ptr_q;
   assign contested = req0 && req1 && !own0 && !own1;
`else
   assign prio = REQ_CORE;
`endif

   always_comb begin
      own0 = lock_q && (state == OWN0) && req0;
      own1 = lock_q && (state == OWN1) && req1;
      win  = pick(req0, req1, own0, own1, prio);
   end

   assign rdata0 = doutb;
   assign rdata1 = doutb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         lock_q  <= 1'b0;
         tag_q   <= REQ_CORE;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         enb     <= 1'b0;
         web     <= '0;
         addrb   <= '0;
         dinb    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         ptr_q   <= REQ_CORE;
`endif
      end else begin
         gnt0    <= win[0];
         gnt1    <= win[1];
         enb     <= |win;
         // Read issued last cycle: RAM answers now, steer by the owner tag.
         rvalid0 <= enb && (web == '0) && (tag_q == REQ_CORE);
         rvalid1 <= enb && (web == '0) && (tag_q == REQ_DMA);
         if (win[0]) begin
            web    <= we0;
            addrb  <= addr0;
            dinb   <= wdata0;
            tag_q  <= REQ_CORE;
            state  <= OWN0;
            lock_q <= lock0;
         end else if (win[1]) begin
            web    <= we1;
            addrb  <= addr1;
            dinb   <= wdata1;
            tag_q  <= REQ_DMA;
            state  <= OWN1;
            lock_q <= lock1;
         end else begin
            web    <= '0;
            state  <= IDLE;
            lock_q <= 1'b0;
         end
`ifdef ARB_ROUND_ROBIN_EN
         if (contested) ptr_q <= win[0];
`endif
      end
   end

endmodule

// File: tb/tb_ram_portb_arbiter.sv
// Directed bench for ram_portb_arbiter with a behavioural byte-writable RAM on port B.
module tb_ram_portb_arbiter;
   import elbeth_mem_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [BW-1:0] we0 = '0, we1 = '0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          lock0 = 1'b0, lock1 = 1'b0;
   logic          gnt0, gnt1, rvalid0, rvalid1, enb;
   logic [DW-1:0] rdata0, rdata1, dinb;
   logic [DW-1:0] doutb = '0;
   logic [BW-1:0] web;
   logic [AW-1:0] addrb;

   logic [DW-1:0] mem [256];
   int total = 0;
   int bad   = 0;

   ram_portb_arbiter #(.AW(AW), .DW(DW), .BW(BW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb)
   );

   always #5 clk = ~clk;

   // Read-first synchronous RAM, one-cycle read latency.
   always @(posedge clk) begin
      if (enb) begin
         for (int i = 0; i < BW; i++)
            if (web[i]) mem[addrb[7:0]][8*i +: 8] <= dinb[8*i +: 8];
         doutb <= mem[addrb[7:0]];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] exp_g0, exp_g1;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = 32'hDEADBEEF;
      mem[8'h30] = 32'hFFFFFFFF;

      // Reset state
      tick();
      chk("rst_enb", enb, 0);
      chk("rst_web", web, 0);
      chk("rst_addrb", addrb, 0);
      chk("rst_dinb", dinb, 0);
      chk("rst_gnt", {gnt1, gnt0}, 0);
      chk("rst_rvalid", {rvalid1, rvalid0}, 0);
      chk("rst_state", dut.state, IDLE);
      rst = 1'b0;

      // 1: single read by core
      req0 = 1'b1; addr0 = 32'h10; we0 = '0;
      tick();
      chk("t1_gnt0", gnt0, 1);
      chk("t1_gnt1", gnt1, 0);
      chk("t1_enb", enb, 1);
      chk("t1_addrb", addrb, 32'h10);
      chk("t1_web", web, 0);
      req0 = 1'b0;
      tick();
      chk("t1_rvalid0", rvalid0, 1);
      chk("t1_rdata0", rdata0, 32'hDEADBEEF);
      chk("t1_rvalid1", rvalid1, 0);
      chk("t1_enb_idle", enb, 0);

      // 2: both held four cycles, no lock
      req0 = 1'b1; req1 = 1'b1; addr0 = 32'h10; addr1 = 32'h10;
`ifdef ARB_ROUND_ROBIN_EN
      exp_g0 = 4'b0101; exp_g1 = 4'b1010;
`else
      exp_g0 = 4'b1111; exp_g1 = 4'b0000;
`endif
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("t2_gnt0_%0d", i), gnt0, exp_g0[i]);
         chk($sformatf("t2_gnt1_%0d", i), gnt1, exp_g1[i]);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      tick();

      // 3: locked write burst by DMA, core waits
      req1 = 1'b1; we1 = 4'hF; addr1 = 32'h20; wdata1 = 32'h12345678; lock1 = 1'b1;
      tick();
      chk("t3_b1_gnt1", gnt1, 1);
      chk("t3_b1_dinb", dinb, 32'h12345678);
      req0 = 1'b1; we0 = '0; addr0 = 32'h20;
      tick();
      chk("t3_b2_gnt1", gnt1, 1);
      chk("t3_b2_gnt0", gnt0, 0);
      tick();
      chk("t3_b3_gnt1", gnt1, 1);
      chk("t3_b3_gnt0", gnt0, 0);
      chk("t3_b3_rvalid1", rvalid1, 0);
      req1 = 1'b0; lock1 = 1'b0; we1 = '0;
      tick();
      chk("t3_gnt0", gnt0, 1);
      chk("t3_gnt1", gnt1, 0);
      chk("t3_addrb", addrb, 32'h20);
      req0 = 1'b0;
      tick();
      chk("t3_rvalid0", rvalid0, 1);
      chk("t3_rdata0", rdata0, 32'h12345678);

      // 4: byte write then readback
      req0 = 1'b1; we0 = 4'b0010; addr0 = 32'h30; wdata0 = 32'h0000AB00;
      tick();
      chk("t4_gnt0", gnt0, 1);
      chk("t4_web", web, 4'b0010);
      req0 = 1'b0; we0 = '0;
      tick();
      chk("t4_no_rvalid", rvalid0, 0);
      req0 = 1'b1;
      tick();
      req0 = 1'b0;
      tick();
      chk("t4_rvalid0", rvalid0, 1);
      chk("t4_rdata0", rdata0, 32'hFFFFABFF);

      // 5: reset right after a read grant
      req0 = 1'b1; addr0 = 32'h10;
      tick();
      chk("t5_gnt0", gnt0, 1);
      req0 = 1'b0;
      rst = 1'b1;
      #1;
      chk("t5_enb", enb, 0);
      chk("t5_state", dut.state, IDLE);
      tick();
      chk("t5_rvalid0", rvalid0, 0);
      rst = 1'b0;
      tick();
      chk("t5_rvalid0_late", rvalid0, 0);
      req1 = 1'b1; we1 = '0; addr1 = 32'h20;
      tick();
      chk("t5_gnt1", gnt1, 1);
      chk("t5_addrb", addrb, 32'h20);
      req1 = 1'b0;
      tick();
      chk("t5_rvalid1", rvalid1, 1);
      chk("t5_rdata1", rdata1, 32'h12345678);
      chk("t5_rvalid0_n", rvalid0, 0);

      // 6: core pulses while DMA holds the lock
      req1 = 1'b1; lock1 = 1'b1; addr1 = 32'h10;
      tick();
      chk("t6_gnt1_a", gnt1, 1);
      req0 = 1'b1; addr0 = 32'h44;
      tick();
      chk("t6_gnt0_a", gnt0, 0);
      chk("t6_addrb_a", addrb, 32'h10);
      req0 = 1'b0;
      tick();
      chk("t6_gnt1_b", gnt1, 1);
      chk("t6_addrb_b", addrb, 32'h10);
      req1 = 1'b0; lock1 = 1'b0;
      tick();
      chk("t6_gnt0_b", gnt0, 0);
      chk("t6_enb", enb, 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
